// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus device port between NrHosts requesters.
// An in-order ID FIFO routes each device response back to the host that issued it.
module bus_rr_arbiter #(
    parameter int NrHosts        = 2,
    parameter int AddressWidth   = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]  host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              device_req_o,
    input  logic                              device_gnt_i,
    output logic [AddressWidth-1:0]           device_addr_o,
    output logic                              device_we_o,
    output logic [DataWidth/8-1:0]            device_be_o,
    output logic [DataWidth-1:0]              device_wdata_o,
    input  logic                              device_rvalid_i,
    input  logic [DataWidth-1:0]              device_rdata_i,
    input  logic                              device_err_i,
    output logic                              busy_o,
    output logic                              protocol_err_o
);

    localparam int IdW  = $clog2(NrHosts);
    localparam int FpW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = DataWidth / 8;

    function automatic logic [NrHosts-1:0] onehot(input logic [IdW-1:0] idx);
        logic [NrHosts-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [FpW-1:0] fifo_inc(input logic [FpW-1:0] ptr);
        return (MaxOutstanding == 1) ? {FpW{1'b0}} : ptr + FpW'(1);
    endfunction

    logic [IdW-1:0]          ptr_r;
    logic [IdW-1:0]          id_mem_r [MaxOutstanding];
    logic [FpW-1:0]          wr_ptr_r;
    logic [FpW-1:0]          rd_ptr_r;
    logic [CntW-1:0]         count_r;
    logic [CntW-1:0]         count_next_s;
    logic                    busy_r;
    logic                    protocol_err_r;

    logic [AddressWidth-1:0] addr_arr_s  [NrHosts];
    logic [BeW-1:0]          be_arr_s    [NrHosts];
    logic [DataWidth-1:0]    wdata_arr_s [NrHosts];

    logic [IdW-1:0]          lo_id_s;
    logic [IdW-1:0]          hi_id_s;
    logic                    hi_found_s;
    logic [IdW-1:0]          winner_s;
    logic                    any_req_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    accept_s;
    logic                    pop_s;
    logic [IdW-1:0]          head_id_s;

    for (genvar g = 0; g < NrHosts; g++) begin : g_slice
        assign addr_arr_s[g]  = host_addr_i[g*AddressWidth +: AddressWidth];
        assign be_arr_s[g]    = host_be_i[g*BeW +: BeW];
        assign wdata_arr_s[g] = host_wdata_i[g*DataWidth +: DataWidth];
    end

    assign any_req_s = |host_req_i;
    assign full_s    = (count_r == CntW'(MaxOutstanding));
    assign empty_s   = (count_r == CntW'(0));

    // Winner search: lowest requester at or above ptr, else lowest requester overall (wrap)
    always_comb begin
        lo_id_s    = '0;
        hi_id_s    = '0;
        hi_found_s = 1'b0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            lo_id_s    = host_req_i[i] ? IdW'(i) : lo_id_s;
            hi_id_s    = (host_req_i[i] && (IdW'(i) >= ptr_r)) ? IdW'(i) : hi_id_s;
            hi_found_s = (host_req_i[i] && (IdW'(i) >= ptr_r)) ? 1'b1 : hi_found_s;
        end
        winner_s = hi_found_s ? hi_id_s : lo_id_s;
    end

    assign device_req_o   = any_req_s & ~full_s;
    assign accept_s       = device_req_o & device_gnt_i;
    assign device_addr_o  = addr_arr_s[winner_s];
    assign device_we_o    = host_we_i[winner_s];
    assign device_be_o    = be_arr_s[winner_s];
    assign device_wdata_o = wdata_arr_s[winner_s];
    assign host_gnt_o     = accept_s ? onehot(winner_s) : {NrHosts{1'b0}};

    assign pop_s         = device_rvalid_i & ~empty_s;
    assign head_id_s     = id_mem_r[rd_ptr_r];
    assign host_rvalid_o = pop_s ? onehot(head_id_s) : {NrHosts{1'b0}};
    assign host_err_o    = (pop_s & device_err_i) ? onehot(head_id_s) : {NrHosts{1'b0}};
    assign host_rdata_o  = device_rdata_i;

    assign busy_o         = busy_r;
    assign protocol_err_o = protocol_err_r;

    // Occupancy update; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_next_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + CntW'(1);
            2'b01:   count_next_s = count_r - CntW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // RR pointer, ID FIFO, busy and sticky protocol-error state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r          <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            busy_r         <= 1'b0;
            protocol_err_r <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                id_mem_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                id_mem_r[wr_ptr_r] <= winner_s;
                wr_ptr_r           <= fifo_inc(wr_ptr_r);
                ptr_r              <= (winner_s == IdW'(NrHosts - 1)) ? IdW'(0) : winner_s + IdW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= fifo_inc(rd_ptr_r);
            end
            count_r        <= count_next_s;
            busy_r         <= (count_next_s != CntW'(0));
            protocol_err_r <= protocol_err_r | (device_rvalid_i & empty_s);
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed, table-driven bench for bus_rr_arbiter (2 hosts, 2 outstanding).
module tb_bus_rr_arbiter;

    localparam int NH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic            clk;
    logic            rst_n;
    logic [NH-1:0]   host_req;
    logic [NH-1:0]   host_gnt;
    logic [NH*AW-1:0] host_addr;
    logic [NH-1:0]   host_we;
    logic [NH*4-1:0] host_be;
    logic [NH*DW-1:0] host_wdata;
    logic [NH-1:0]   host_rvalid;
    logic [DW-1:0]   host_rdata;
    logic [NH-1:0]   host_err;
    logic            dev_req;
    logic            dev_gnt;
    logic [AW-1:0]   dev_addr;
    logic            dev_we;
    logic [3:0]      dev_be;
    logic [DW-1:0]   dev_wdata;
    logic            dev_rvalid;
    logic [DW-1:0]   dev_rdata;
    logic            dev_err;
    logic            busy;
    logic            perr;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] h_addr  [NH];
    logic          h_we    [NH];
    logic [3:0]    h_be    [NH];
    logic [DW-1:0] h_wdata [NH];

    bus_rr_arbiter #(
        .NrHosts(NH), .AddressWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_gnt_i(dev_gnt), .device_addr_o(dev_addr),
        .device_we_o(dev_we), .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .busy_o(busy), .protocol_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic        e_dreq;
        logic        e_busy;
        logic        e_perr;
        int          e_host;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] req, input logic gnt, input logic rv, input logic err,
                       input logic [31:0] rdata, input logic [1:0] e_gnt, input logic [1:0] e_rv,
                       input logic [1:0] e_err, input logic e_dreq, input logic e_busy,
                       input logic e_perr, input int e_host);
        vec_t v;
        v = '{req, gnt, rv, err, rdata, e_gnt, e_rv, e_err, e_dreq, e_busy, e_perr, e_host};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        check({s, ".host_gnt"}, 64'(host_gnt), 64'(v.e_gnt));
        check({s, ".host_rvalid"}, 64'(host_rvalid), 64'(v.e_rv));
        check({s, ".host_err"}, 64'(host_err), 64'(v.e_err));
        check({s, ".device_req"}, 64'(dev_req), 64'(v.e_dreq));
        check({s, ".busy"}, 64'(busy), 64'(v.e_busy));
        check({s, ".protocol_err"}, 64'(perr), 64'(v.e_perr));
        check({s, ".device_addr"}, 64'(dev_addr), 64'(h_addr[v.e_host]));
        check({s, ".device_we"}, 64'(dev_we), 64'(h_we[v.e_host]));
        check({s, ".device_be"}, 64'(dev_be), 64'(h_be[v.e_host]));
        check({s, ".device_wdata"}, 64'(dev_wdata), 64'(h_wdata[v.e_host]));
        if (v.e_rv != 2'b00) begin
            check({s, ".host_rdata"}, 64'(host_rdata), 64'(v.rdata));
        end
    endtask

    initial begin
        h_addr[0] = 32'h0000_0100; h_we[0] = 1'b0; h_be[0] = 4'hF; h_wdata[0] = 32'h1111_0000;
        h_addr[1] = 32'h0000_0200; h_we[1] = 1'b1; h_be[1] = 4'h3; h_wdata[1] = 32'h2222_0001;
        host_addr  = {h_addr[1], h_addr[0]};
        host_we    = {h_we[1], h_we[0]};
        host_be    = {h_be[1], h_be[0]};
        host_wdata = {h_wdata[1], h_wdata[0]};
        host_req   = 2'b00;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = 32'h0;
        dev_err    = 1'b0;
        rst_n      = 1'b0;

        // Alternation H0,H1,... with responses one cycle after each grant
        add(2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        add(2'b11, 1'b1, 1'b1, 1'b0, 32'hA000_0100, 2'b10, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1);
        add(2'b11, 1'b1, 1'b1, 1'b0, 32'hB000_0200, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        add(2'b11, 1'b1, 1'b1, 1'b1, 32'hA000_0100, 2'b10, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1);
        add(2'b00, 1'b1, 1'b1, 1'b0, 32'hB000_0200, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        // FIFO full: H0 three requests, third held until a pop registers
        add(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b01, 1'b1, 1'b1, 1'b0, 32'hA000_0100, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b1, 1'b0, 32'hA000_0100, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b1, 1'b0, 32'hA000_0100, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        // Device stalls H1 for 5 cycles (ptr=1 held), then grants; ptr wraps to 0
        for (int i = 0; i < 5; i++) begin
            add(2'b10, 1'b0, 1'b0, 1'b0, 32'h0,     2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1);
        end
        add(2'b10, 1'b1, 1'b0, 1'b0, 32'h0,         2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1);
        add(2'b11, 1'b1, 1'b1, 1'b0, 32'hB000_0200, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b1, 1'b0, 32'hA000_0100, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        add(2'b00, 1'b1, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        // Stray response with empty FIFO sets the sticky error next cycle
        add(2'b00, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        add(2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 0);
        add(2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 0);

        // Reset state
        #1;
        check("reset.host_gnt", 64'(host_gnt), 64'h0);
        check("reset.host_rvalid", 64'(host_rvalid), 64'h0);
        check("reset.host_err", 64'(host_err), 64'h0);
        check("reset.device_req", 64'(dev_req), 64'h0);
        check("reset.busy", 64'(busy), 64'h0);
        check("reset.protocol_err", 64'(perr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            host_req   = vecs[i].req;
            dev_gnt    = vecs[i].gnt;
            dev_rvalid = vecs[i].rv;
            dev_err    = vecs[i].err;
            dev_rdata  = vecs[i].rdata;
            #1;
            check_vec(vecs[i], i);
            @(negedge clk);
        end

        // Reset clears the sticky protocol error
        host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst2.protocol_err", 64'(perr), 64'h0);
        check("rst2.busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-operation reset: the late response is treated as a stray one
        host_req = 2'b01; dev_gnt = 1'b1;
        #1;
        check("mid.host_gnt", 64'(host_gnt), 64'h1);
        @(negedge clk);
        #1;
        check("mid.busy_before_reset", 64'(busy), 64'h1);
        host_req = 2'b00;
        rst_n = 1'b0;
        #1;
        check("mid.busy_in_reset", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dev_rvalid = 1'b1; dev_rdata = 32'hA000_0100;
        #1;
        check("mid.host_rvalid", 64'(host_rvalid), 64'h0);
        check("mid.protocol_err_same_cycle", 64'(perr), 64'h0);
        @(negedge clk);
        dev_rvalid = 1'b0;
        #1;
        check("mid.protocol_err", 64'(perr), 64'h1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
